ysyx_25040111_lsu_axi: RTL
==========================

Name: ysyx_25040111_lsu_axi

Overview:
Parametrised load/store unit. It converts one core memory request at a time into a single-beat AXI4 transaction on a configurable-width master port. It adds over the previous LSU:
- explicit reset and a request/response valid-ready handshake;
- generic DATA_W lane steering (32/64);
- misalignment detection;
- a bus-error and timeout status field instead of halting the simulation.

It sits between EXU/WBU and the AXI crossbar.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, AXI data width; legal values 32 or 64
AXI_ID, 0, constant value driven on awid/arid
TIMEOUT, 1024, cycles from issue to response before aborting; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_wen  in  1  1=store, 0=load
req_sign  in  1  sign-extend load result
req_size  in  2  access size: 0=B, 1=H, 2=W, 3=D (D legal only when DATA_W=64)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, LSB-justified
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid&resp_ready
resp_rdata  out  DATA_W  load data, extended; 0 for stores
resp_err  out  2  status: 0=OK, 1=misaligned/illegal size, 2=SLVERR/DECERR, 3=timeout
axi_aw{valid,ready,addr,id,len,size,burst}  AXI4 write-address channel: len=0, burst=INCR(01), size=req_size
axi_w{valid,ready,data,strb,last}  AXI4 write-data channel: last=1 whenever wvalid=1
axi_b{valid,ready,resp,id}  AXI4 write-response channel
axi_ar{valid,ready,addr,id,len,size,burst}  AXI4 read-address channel
axi_r{valid,ready,data,resp,last,id}  AXI4 read-data channel

Behaviour:
- Reset (rst=1 at a posedge) forces IDLE, regardless of state. Post-reset outputs:
  - req_ready=1;
  - resp_valid, awvalid, wvalid, arvalid = 0;
  - resp_rdata=0, resp_err=0, timeout counter=0.
  - bready=1 and rready=1 in IDLE, so stale responses drain.
- State machine:
  - IDLE: req_ready=1. On accept, latch addr, wdata, size, sign, wen. Next state:
    - misaligned (addr mod 2^size != 0) or illegal size → RESP, err=1, no bus activity;
    - else store → WR, with awvalid=1 and wvalid=1 in the same next cycle;
    - else load → AR, with arvalid=1.
  - AR: hold arvalid and araddr stable until arready, then → R.
  - R: rready=1. On rvalid: capture data and map rresp[1] to err=2; → RESP.
  - WR: awvalid and wvalid each drop independently on their own handshake. When both handshakes are done → B. Handshakes may complete in the same cycle or in either order.
  - B: bready=1. On bvalid: map bresp[1] to err=2; → RESP.
  - RESP: resp_valid=1, outputs stable until resp_ready, then → IDLE (req_ready=1 in the following cycle).
- Latency:
  - Best case load: accept at cycle 0, arvalid at 1, rvalid at 2, resp_valid at 3.
  - Misaligned access: resp_valid in the cycle after accept.
- Lane steering, with off = addr[log2(DATA_W/8)-1:0]:
  - wdata = req_wdata << (8*off);
  - wstrb = ((1<<(1<<size))-1) << off, truncated to DATA_W/8 bits;
  - araddr and awaddr = full unmasked address.
- Read data: shifted = rdata >> (8*off), then zero- or sign-extended from bit 8·2^size−1 per req_sign. size=3 passes the data unmodified.
- rid, bid and rlast are ignored. An rresp/bresp of EXOKAY (01) is treated as OK.
- Timeout (TIMEOUT>0):
  - counter clears on accept and increments in AR/R/WR/B;
  - at count==TIMEOUT-1, deassert all valids → RESP, err=3, rdata=0;
  - a late B/R that arrives while in IDLE or RESP is consumed and discarded.
- Simultaneous events: rvalid in the same cycle as the timeout terminal count → the data wins (err per rresp).
- req_valid held during RESP is not accepted until IDLE.

Test Plan:
- DATA_W=32, lb addr=0x80000003, sign=1, slave returns rdata=0x80FF_0000 → araddr=0x80000003, arsize=0; resp_rdata=0xFFFFFF80, err=0, resp_valid 3 cycles after accept with zero-wait slave.
- DATA_W=64, sh addr=0x0000_0106, wdata=0xBEEF → awsize=1, wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, wlast=1; awready delayed 3 cycles while wready is immediate → single B, err=0.
- lw addr=0x1002 → no arvalid ever asserted; resp_valid next cycle, err=1. size=3 with DATA_W=32 → err=1.
- Store with bresp=2'b10, then load with rresp=2'b11 → err=2 on both; the unit returns to IDLE and accepts the next request.
- TIMEOUT=8, arready never asserted → arvalid drops after 8 cycles, err=3. An rvalid injected later in IDLE is absorbed with no resp_valid.
- Assert rst while in B with bvalid pending → next cycle: IDLE, req_ready=1, all valids 0, resp_valid=0.

Source files
------------

// File: rtl/ysyx_25040111_lsu_axi_if.sv
// Single-beat AXI4 master/slave bundle between the load/store unit and the crossbar.
// A beat transfers on a rising clk edge where valid and ready are both high; a sender holds valid and payload stable until then.
interface ysyx_25040111_lsu_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;

    logic                arvalid;
    logic                arready;
    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [ID_W-1:0]     rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_25040111_lsu_axi.sv
// Load/store unit: one core request at a time becomes one single-beat AXI4 transaction,
// with byte-lane steering, misalignment detection and a bus-error/timeout status code.
module ysyx_25040111_lsu_axi #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int AXI_ID  = 0,
    parameter int TIMEOUT = 1024,
    parameter int ID_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic              req_sign,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    ysyx_25040111_lsu_axi_if.master axi,
    output logic [2:0]        dbg_state
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                sign_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                arvalid_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [31:0]         cnt;

    logic [OFF_W-1:0]    req_off;
    logic                bad_size;
    logic                misaligned;
    logic [STRB_W-1:0]   strb_base;
    logic [STRB_W-1:0]   req_strb;
    logic [DATA_W-1:0]   req_wdata_sh;
    logic [DATA_W-1:0]   rd_sh;
    logic [DATA_W-1:0]   rd_ext;
    logic                rd_msb;
    int                  ext_w;
    logic                tmo;
    logic                aw_pending;
    logic                w_pending;

    assign req_off      = req_addr[OFF_W-1:0];
    assign bad_size     = (req_size == 2'd3) && (DATA_W == 32);
    assign strb_base    = STRB_W'((1 << (1 << req_size)) - 1);
    assign req_strb     = strb_base << req_off;
    assign req_wdata_sh = req_wdata << {req_off, 3'b000};
    assign rd_sh        = axi.rdata >> {addr_q[OFF_W-1:0], 3'b000};
    assign tmo          = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));
    assign aw_pending   = awvalid_q && !axi.awready;
    assign w_pending    = wvalid_q && !axi.wready;

    always_comb begin
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Extension width follows the latched size; a full-width access passes straight through.
    always_comb begin
        ext_w  = DATA_W;
        rd_msb = rd_sh[DATA_W-1];
        case (size_q)
            2'd0: begin ext_w = 8;  rd_msb = rd_sh[7];  end
            2'd1: begin ext_w = 16; rd_msb = rd_sh[15]; end
            2'd2: begin ext_w = 32; rd_msb = rd_sh[31]; end
            default: ;
        endcase
        for (int i = 0; i < DATA_W; i++)
            rd_ext[i] = (i < ext_w) ? rd_sh[i] : (sign_q & rd_msb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        size_q <= req_size;
                        sign_q <= req_sign;
                        cnt    <= '0;
                        if (bad_size || misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 2'd1;
                        end else if (req_wen) begin
                            state     <= S_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            wdata_q   <= req_wdata_sh;
                            wstrb_q   <= req_strb;
                        end else begin
                            state     <= S_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    cnt <= cnt + 32'd1;
                    if (tmo) begin
                        arvalid_q  <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'd3;
                    end else if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= S_R;
                    end
                end
                // Returned data takes priority over an expiring timeout.
                S_R: begin
                    cnt <= cnt + 32'd1;
                    if (axi.rvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_ext;
                        resp_err   <= axi.rresp[1] ? 2'd2 : 2'd0;
                    end else if (tmo) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'd3;
                    end
                end
                S_WR: begin
                    cnt <= cnt + 32'd1;
                    if (tmo) begin
                        awvalid_q  <= 1'b0;
                        wvalid_q   <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'd3;
                    end else begin
                        awvalid_q <= aw_pending;
                        wvalid_q  <= w_pending;
                        if (!aw_pending && !w_pending)
                            state <= S_B;
                    end
                end
                S_B: begin
                    cnt <= cnt + 32'd1;
                    if (axi.bvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= axi.bresp[1] ? 2'd2 : 2'd0;
                    end else if (tmo) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 2'd3;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign dbg_state   = state;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awid    = ID_W'(AXI_ID);
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = wvalid_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arid    = ID_W'(AXI_ID);
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;

    // Responses are also accepted while idle or responding so a late beat after a timeout drains.
    assign axi.bready  = (state == S_IDLE) || (state == S_B) || (state == S_RESP);
    assign axi.rready  = (state == S_IDLE) || (state == S_R) || (state == S_RESP);

    logic unused_ok;
    assign unused_ok = ^{axi.rid, axi.bid, axi.rlast, axi.rresp[0], axi.bresp[0]};
endmodule
